// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel clock-enable generator.
//
// Each channel makes a one-cycle enable pulse (ce) and a square wave (clk_out)
// that toggles on every pulse. All of it runs on the single system clock.
// A channel runs in one of two modes:
//   - fractional: a phase accumulator. The carry out of st + inc becomes ce,
//     so the average rate is exact.
//   - integer: a counter. It wraps and pulses when st reaches the terminal
//     count.
//
// Parameters:
//   ACC_W     accumulator/counter width per channel
//   NCH       number of channels
// Ports:
//   clk       system clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   inc       per-channel increment (fractional) or terminal count (integer),
//             channel i at [i*ACC_W +: ACC_W]
//   mode      per channel: 0 fractional, 1 integer divide
//   en        per-channel run enable
//   speed_2x  double-speed select, applies to all channels
//   sync_clr  synchronous clear of all channels
//   ce        one-cycle enable pulse per channel, registered
//   clk_out   per-channel square wave, toggles on every ce
module clk_en_gen #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned NCH   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*ACC_W-1:0] inc,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH-1:0]       en,
  input  logic                 speed_2x,
  input  logic                 sync_clr,
  output logic [NCH-1:0]       ce,
  output logic [NCH-1:0]       clk_out
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [ACC_W-1:0] inc_ch;
    logic [ACC_W-1:0] inc_eff;
    logic [ACC_W-1:0] term;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] st_q, st_d;
    logic             mode_q, mode_d;
    logic             ce_q, ce_d;
    logic             clk_q, clk_d;

    assign inc_ch = inc[i*ACC_W +: ACC_W];

    always_comb begin
      // Doubling saturates at all-ones. This keeps the fractional rate just
      // below one pulse per cycle instead of wrapping to a tiny increment.
      inc_eff = inc_ch;
      if (speed_2x) begin
        inc_eff = inc_ch[ACC_W-1] ? '1 : (inc_ch << 1);
      end
      term = speed_2x ? (inc_ch >> 1) : inc_ch;
      sum  = {1'b0, st_q} + {1'b0, inc_eff};

      st_d   = st_q;
      mode_d = mode_q;
      ce_d   = 1'b0;
      clk_d  = clk_q;

      if (sync_clr) begin
        st_d   = '0;
        mode_d = mode[i];
        clk_d  = 1'b0;
      end else if (mode[i] != mode_q) begin
        // Restart cleanly in the new mode. The square wave keeps its level.
        st_d   = '0;
        mode_d = mode[i];
      end else if (!en[i]) begin
        // Paused: hold phase, suppress pulses.
      end else if (!mode_q) begin
        st_d = sum[ACC_W-1:0];
        ce_d = sum[ACC_W];
      end else if (st_q >= term) begin
        // >= rather than == so that lowering term below st wraps right away.
        st_d = '0;
        ce_d = 1'b1;
      end else begin
        st_d = st_q + 1'b1;
      end

      if (ce_d) begin
        clk_d = ~clk_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= '0;
        mode_q <= 1'b0;
        ce_q   <= 1'b0;
        clk_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        mode_q <= mode_d;
        ce_q   <= ce_d;
        clk_q  <= clk_d;
      end
    end

    assign ce[i]      = ce_q;
    assign clk_out[i] = clk_q;
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Testbench for clk_en_gen (ACC_W=8, NCH=2).
// Stimulus pushes the expected pulse (edge number and clk_out level) into a
// per-channel queue. A negedge monitor pops an entry on every ce and compares
// it. Each scenario ends with a check that every expected pulse was seen.
module tb_clk_en_gen;
  localparam int unsigned ACC_W = 8;
  localparam int unsigned NCH   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH*ACC_W-1:0] inc;
  logic [NCH-1:0]       mode;
  logic [NCH-1:0]       en;
  logic                 speed_2x;
  logic                 sync_clr;
  logic [NCH-1:0]       ce;
  logic [NCH-1:0]       clk_out;

  clk_en_gen #(
    .ACC_W(ACC_W),
    .NCH  (NCH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (inc),
    .mode    (mode),
    .en      (en),
    .speed_2x(speed_2x),
    .sync_clr(sync_clr),
    .ce      (ce),
    .clk_out (clk_out)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge k, cyc == k.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int unsigned at;
    logic        lvl;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int ch, input int unsigned at, input logic lvl);
    exp_t e;
    e.at  = at;
    e.lvl = lvl;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  // Regular pulse train starting from clk_out=0.
  task automatic push_train(input int ch, input int unsigned first, input int unsigned period,
                            input int count);
    for (int k = 0; k < count; k++) begin
      push(ch, first + k * period, (k % 2 == 0) ? 1'b1 : 1'b0);
    end
  endtask

  // Advance n cycles and land just after the monitor's negedge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drained(input string name);
    check({name, "_ch0_missing_pulses"}, q0.size(), 0);
    check({name, "_ch1_missing_pulses"}, q1.size(), 0);
  endtask

  // Apply settings with one sync_clr edge and return that edge's number.
  task automatic start(input logic [1:0] m, input logic [15:0] iv, input logic [1:0] e,
                       input logic sp, output int unsigned e0);
    mode     = m;
    inc      = iv;
    en       = e;
    speed_2x = sp;
    sync_clr = 1'b1;
    step(1);
    sync_clr = 1'b0;
    e0       = cyc;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic have;
    if (rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (ce[ch]) begin
          have = 1'b0;
          if (ch == 0 && q0.size() != 0) begin
            e    = q0.pop_front();
            have = 1'b1;
          end else if (ch == 1 && q1.size() != 0) begin
            e    = q1.pop_front();
            have = 1'b1;
          end
          if (!have) begin
            n_checks++;
            n_errors++;
            $display("FAIL ch%0d_unexpected_pulse: ce=1 at cycle %0d, none expected", ch, cyc);
          end else begin
            check($sformatf("ch%0d_pulse_cycle", ch), cyc, e.at);
            check($sformatf("ch%0d_pulse_clk_out", ch), clk_out[ch], e.lvl);
          end
        end
      end
    end
  end

  initial begin
    int unsigned e0;
    int          offs[6];
    offs     = '{3, 6, 8, 11, 14, 16};
    rst_n    = 1'b0;
    sync_clr = 1'b0;
    mode     = '0;
    en       = '0;
    inc      = '0;
    speed_2x = 1'b0;
    step(2);
    check("reset_ce", ce, 0);
    check("reset_clk_out", clk_out, 0);
    rst_n = 1'b1;
    step(1);

    // Integer divide on both channels: term 23 (period 24) and term 5 (period 6).
    start(2'b11, {8'd5, 8'd23}, 2'b11, 1'b0, e0);
    push_train(0, e0 + 24, 24, 3);
    push_train(1, e0 + 6, 6, 13);
    step(80);
    drained("int_div");

    // Fractional inc=96: carries on edges 3, 6, 8, repeating every 8.
    start(2'b00, {8'd0, 8'd96}, 2'b01, 1'b0, e0);
    for (int k = 0; k < 6; k++) push(0, e0 + offs[k], (k % 2 == 0) ? 1'b1 : 1'b0);
    step(17);
    drained("frac96");

    // Integer double speed: term 23>>1 = 11, period 12.
    start(2'b01, {8'd0, 8'd23}, 2'b01, 1'b1, e0);
    push_train(0, e0 + 12, 12, 3);
    step(40);
    drained("int_2x");

    // Fractional 200 doubled saturates to 255: pulses on edges 2..256, not on 1 or 257.
    start(2'b00, {8'd0, 8'd200}, 2'b01, 1'b1, e0);
    push_train(0, e0 + 2, 1, 255);
    step(257);
    drained("frac_2x_sat");

    // Terminal lowered from 100 to 10 while st=50: wrap on next edge, then period 11.
    start(2'b01, {8'd0, 8'd100}, 2'b01, 1'b0, e0);
    step(50);
    inc = {8'd0, 8'd10};
    push_train(0, e0 + 51, 11, 3);
    step(25);
    drained("term_lowered");

    // Enable low for 5 edges at st=10: phase frozen, so pulses slip by 5.
    start(2'b01, {8'd0, 8'd23}, 2'b01, 1'b0, e0);
    step(10);
    en = 2'b00;
    step(5);
    en = 2'b01;
    push_train(0, e0 + 29, 24, 2);
    step(50);
    drained("en_pause");

    // Mode toggled away and back: two clearing edges, no pulse on either.
    start(2'b01, {8'd0, 8'd23}, 2'b01, 1'b0, e0);
    step(10);
    mode = 2'b00;
    step(1);
    mode = 2'b01;
    push(0, e0 + 36, 1'b1);
    step(30);
    drained("mode_toggle");
    check("clk_out_high_before_clr", clk_out[0], 1);

    // sync_clr with en low, held 3 cycles: outputs low, then restart from st=0.
    sync_clr = 1'b1;
    en       = 2'b00;
    step(1);
    check("clr_en_low_clk_out", clk_out, 0);
    check("clr_en_low_ce", ce, 0);
    step(2);
    check("clr_held_clk_out", clk_out, 0);
    sync_clr = 1'b0;
    en       = 2'b01;
    e0       = cyc;
    push(0, e0 + 24, 1'b1);
    step(30);
    drained("clr_restart");

    // Async reset mid-pulse: term 0 gives ce=1, clk_out=1 after the first edge.
    start(2'b01, {8'd0, 8'd0}, 2'b01, 1'b0, e0);
    push(0, e0 + 1, 1'b1);
    step(1);
    check("pre_reset_ce", ce[0], 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ce", ce, 0);
    check("async_reset_clk_out", clk_out, 0);
    mode = 2'b00;
    inc  = {8'd0, 8'd96};
    en   = 2'b01;
    step(2);
    rst_n = 1'b1;
    e0    = cyc;
    for (int k = 0; k < 3; k++) push(0, e0 + offs[k], (k % 2 == 0) ? 1'b1 : 1'b0);
    step(9);
    drained("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
